// File: rtl/bidir_pad_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pad_arbiter
// Description : Round-robin owner arbitration for a shared bidirectional pad
//               bank, with tristated turnaround gaps and a hold watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module bidir_pad_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int NUM_BIDIR_PADS = 8,
    parameter int TURNAROUND     = 2,
    parameter int TIMEOUT        = 1024,
    localparam int OW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int PW            = NUM_REQ * NUM_BIDIR_PADS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        rel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic [OW-1:0]             owner,
    output logic                      timeout_evt,
    input  logic [PW-1:0]             slot_out,
    input  logic [PW-1:0]             slot_oe,
    input  logic [PW-1:0]             slot_pu,
    input  logic [PW-1:0]             slot_pd,
    input  logic [PW-1:0]             slot_cs,
    input  logic [PW-1:0]             slot_sl,
    input  logic [PW-1:0]             slot_ie,
    output logic [PW-1:0]             slot_in,
    input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
    output logic [NUM_BIDIR_PADS-1:0] bidir_out,
    output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
    output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] bidir_ie
);

    localparam int W  = NUM_BIDIR_PADS;
    localparam int HW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    // Control bundle order: [6]=ie [5]=sl [4]=cs [3]=pd [2]=pu [1]=oe [0]=out
    localparam logic [6:0][W-1:0] PAD_SAFE = {{W{1'b1}}, {W{1'b0}}, {W{1'b0}},
                                              {W{1'b1}}, {W{1'b0}}, {W{1'b0}},
                                              {W{1'b0}}};

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [OW-1:0]     ptr;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     turn_cnt;
    logic [6:0][W-1:0] pad_q;
    logic [6:0][W-1:0] ctl_arr [NUM_REQ];

    logic              found;
    logic [OW-1:0]     sel;
    logic [OW-1:0]     cand;
    logic [NUM_REQ-1:0] sel_oh;
    logic              rel_normal;
    logic              rel_force;
    logic              turn_done;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
            assign ctl_arr[k] = {slot_ie[k*W +: W], slot_sl[k*W +: W],
                                 slot_cs[k*W +: W], slot_pd[k*W +: W],
                                 slot_pu[k*W +: W], slot_oe[k*W +: W],
                                 slot_out[k*W +: W]};
            assign slot_in[k*W +: W] = (state == ST_GRANT && owner == OW'(k))
                                       ? bidir_in : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Search starts just past the last owner so a repeat requester goes last.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_oh[k] = (sel == OW'(k));
        end
        rel_normal = rel[owner] | ~req[owner];
        rel_force  = (TIMEOUT != 0) && (hold_cnt == HW'(TIMEOUT - 1));
        turn_done  = (turn_cnt == TW'(TURNAROUND - 1));
        state_nx   = state;
        case (state)
            ST_IDLE:  if (found) state_nx = ST_GRANT;
            ST_GRANT: if (rel_normal || rel_force)
                          state_nx = (TURNAROUND == 0) ? ST_IDLE : ST_TURN;
            ST_TURN:  if (turn_done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt         <= '0;
            owner       <= '0;
            ptr         <= OW'(NUM_REQ - 1);
            hold_cnt    <= '0;
            turn_cnt    <= '0;
            timeout_evt <= 1'b0;
            pad_q       <= PAD_SAFE;
        end else begin
            timeout_evt <= (state == ST_GRANT) && rel_force && !rel_normal;
            pad_q       <= PAD_SAFE;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        gnt      <= sel_oh;
                        owner    <= sel;
                        ptr      <= sel;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (rel_normal || rel_force) begin
                        gnt      <= '0;
                        turn_cnt <= '0;
                    end else begin
                        pad_q <= ctl_arr[owner];
                        if (hold_cnt != {HW{1'b1}}) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    if (!turn_done) begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    gnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        bidir_out = pad_q[0];
        bidir_oe  = pad_q[1];
        bidir_pu  = pad_q[2];
        bidir_pd  = pad_q[3];
        bidir_cs  = pad_q[4];
        bidir_sl  = pad_q[5];
        bidir_ie  = pad_q[6];
    end

endmodule
`default_nettype wire
